// File: rtl/fine_sr_gen.sv
// Fine thermometer shift register: comp_in is filtered over PASS_NUM matching samples,
// each accepted sample steps the position up or down, and alternating steps raise lock.
module fine_sr_gen #(
    parameter  int WIDTH     = 5,
    parameter  int PASS_NUM  = 4,
    parameter  int WRAP_MODE = 1,
    parameter  int LOCK_NUM  = 8,
    localparam int PW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             comp_in,
    input  logic             fine_en,
    input  logic             load_en,
    input  logic [PW-1:0]    load_pos,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    pos,
    output logic             carry_out_incr,
    output logic             carry_out_decr,
    output logic             lock
);
    localparam logic [PW-1:0] POS_MAX  = PW'(WIDTH);
    localparam logic [7:0]    PASS_CNT = 8'(PASS_NUM);
    localparam logic [7:0]    LOCK_CNT = 8'(LOCK_NUM);

    logic [PW-1:0]    r_pos;
    logic [WIDTH-1:0] r_out;
    logic [7:0]       r_cnt;
    logic             r_dir_q;
    logic [7:0]       r_alt_cnt;
    logic             r_last_dir;
    logic             r_have_last;
    logic             r_lock;
    logic             r_carry_incr;
    logic             r_carry_decr;

    logic [7:0]       w_run;
    logic             w_step;
    logic [PW-1:0]    w_step_pos;
    logic             w_step_incr;
    logic             w_step_decr;
    logic [7:0]       w_alt_next;
    logic [PW-1:0]    w_load_pos;

    function automatic logic [WIDTH-1:0] therm(input logic [PW-1:0] p);
        logic [WIDTH-1:0] t;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = (i < int'(p));
        end
        return t;
    endfunction

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_run       = (r_cnt != 8'd0 && comp_in == r_dir_q) ? r_cnt + 8'd1 : 8'd1;
        w_step      = (w_run == PASS_CNT);
        w_step_pos  = r_pos;
        w_step_incr = 1'b0;
        w_step_decr = 1'b0;
        if (comp_in) begin
            if (r_pos == POS_MAX) begin
                w_step_incr = 1'b1;
                w_step_pos  = (WRAP_MODE != 0) ? '0 : POS_MAX;
            end else begin
                w_step_pos = r_pos + PW'(1);
            end
        end else begin
            if (r_pos == '0) begin
                w_step_decr = 1'b1;
                w_step_pos  = (WRAP_MODE != 0) ? POS_MAX : '0;
            end else begin
                w_step_pos = r_pos - PW'(1);
            end
        end

        // The first step after reset or load has no previous direction to alternate with.
        w_alt_next = 8'd0;
        if (r_have_last && comp_in != r_last_dir) begin
            w_alt_next = (r_alt_cnt == LOCK_CNT) ? r_alt_cnt : r_alt_cnt + 8'd1;
        end

        w_load_pos = (load_pos > POS_MAX) ? POS_MAX : load_pos;
    end

    always_ff @(posedge clk) begin
        r_carry_incr <= 1'b0;
        r_carry_decr <= 1'b0;
        if (rst) begin
            r_pos       <= POS_MAX;
            r_out       <= '1;
            r_cnt       <= 8'd0;
            r_dir_q     <= 1'b0;
            r_alt_cnt   <= 8'd0;
            r_last_dir  <= 1'b0;
            r_have_last <= 1'b0;
            r_lock      <= 1'b0;
        end else if (load_en) begin
            r_pos       <= w_load_pos;
            r_out       <= therm(w_load_pos);
            r_cnt       <= 8'd0;
            r_alt_cnt   <= 8'd0;
            r_have_last <= 1'b0;
            r_lock      <= 1'b0;
        end else if (fine_en) begin
            r_dir_q <= comp_in;
            if (w_step) begin
                r_cnt        <= 8'd0;
                r_pos        <= w_step_pos;
                r_out        <= therm(w_step_pos);
                r_carry_incr <= w_step_incr;
                r_carry_decr <= w_step_decr;
                r_alt_cnt    <= w_alt_next;
                r_last_dir   <= comp_in;
                r_have_last  <= 1'b1;
                r_lock       <= (w_alt_next == LOCK_CNT);
            end else begin
                r_cnt <= w_run;
            end
        end else begin
            r_cnt <= 8'd0;
        end
    end

    assign out            = r_out;
    assign pos            = r_pos;
    assign carry_out_incr = r_carry_incr;
    assign carry_out_decr = r_carry_decr;
    assign lock           = r_lock;

endmodule

// File: tb/tb_fine_sr_gen.sv
// Directed bench for fine_sr_gen: a wrapping and a saturating instance share stimulus,
// a scoreboard queue of modelled results is checked every cycle plus targeted checks.
module tb_fine_sr_gen;
    localparam int W     = 5;
    localparam int PASS  = 4;
    localparam int LOCKN = 4;
    localparam int PW    = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst, comp_in, fine_en, load_en;
    logic [PW-1:0] load_pos;
    logic [W-1:0]  out_w, out_s;
    logic [PW-1:0] pos_w, pos_s;
    logic          ci_w, cd_w, ci_s, cd_s, lock_w, lock_s;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;

    always #5 clk = ~clk;

    fine_sr_gen #(.WIDTH(W), .PASS_NUM(PASS), .WRAP_MODE(1), .LOCK_NUM(LOCKN)) dut_w (
        .clk(clk), .rst(rst), .comp_in(comp_in), .fine_en(fine_en), .load_en(load_en),
        .load_pos(load_pos), .out(out_w), .pos(pos_w), .carry_out_incr(ci_w),
        .carry_out_decr(cd_w), .lock(lock_w));

    fine_sr_gen #(.WIDTH(W), .PASS_NUM(PASS), .WRAP_MODE(0), .LOCK_NUM(LOCKN)) dut_s (
        .clk(clk), .rst(rst), .comp_in(comp_in), .fine_en(fine_en), .load_en(load_en),
        .load_pos(load_pos), .out(out_s), .pos(pos_s), .carry_out_incr(ci_s),
        .carry_out_decr(cd_s), .lock(lock_s));

    typedef struct {
        int pos_w;
        int pos_s;
        bit ci_w;
        bit cd_w;
        bit ci_s;
        bit cd_s;
        bit lock;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state (index 0 = wrapping instance, 1 = saturating instance).
    int m_pos[2];
    bit m_ci[2];
    bit m_cd[2];
    int m_cnt, m_alt;
    bit m_dir, m_last, m_first, m_lock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit l, input bit f, input bit c, input int lp);
        int run;
        m_ci = '{0, 0};
        m_cd = '{0, 0};
        if (r) begin
            m_pos = '{W, W};
            m_cnt = 0; m_dir = 0; m_alt = 0; m_first = 1; m_lock = 0;
        end else if (l) begin
            m_pos[0] = (lp > W) ? W : lp;
            m_pos[1] = m_pos[0];
            m_cnt = 0; m_alt = 0; m_first = 1; m_lock = 0;
        end else if (f) begin
            run   = (m_cnt > 0 && c == m_dir) ? m_cnt + 1 : 1;
            m_dir = c;
            if (run == PASS) begin
                m_cnt = 0;
                for (int k = 0; k < 2; k++) begin
                    if (c) begin
                        if (m_pos[k] == W) begin
                            m_ci[k]  = 1;
                            m_pos[k] = (k == 0) ? 0 : W;
                        end else m_pos[k] = m_pos[k] + 1;
                    end else begin
                        if (m_pos[k] == 0) begin
                            m_cd[k]  = 1;
                            m_pos[k] = (k == 0) ? W : 0;
                        end else m_pos[k] = m_pos[k] - 1;
                    end
                end
                if (m_first) m_alt = 0;
                else if (c != m_last) m_alt = (m_alt + 1 > LOCKN) ? LOCKN : m_alt + 1;
                else m_alt = 0;
                if (!m_first && c == m_last) m_lock = 0;
                else if (m_alt == LOCKN) m_lock = 1;
                m_last  = c;
                m_first = 0;
            end else begin
                m_cnt = run;
            end
        end else begin
            m_cnt = 0;
        end
    endtask

    // Drive one cycle of stimulus, queue the modelled result, then check it after the edge.
    task automatic cyc(input bit r, input bit l, input bit f, input bit c, input int lp);
        exp_t e;
        rst      = r;
        load_en  = l;
        fine_en  = f;
        comp_in  = c;
        load_pos = PW'(lp);
        model(r, l, f, c, lp);
        e = '{m_pos[0], m_pos[1], m_ci[0], m_cd[0], m_ci[1], m_cd[1], m_lock};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        n_cyc++;
        e = sb_q.pop_front();
        chk($sformatf("c%0d pos_w", n_cyc), 32'(pos_w), 32'(e.pos_w));
        chk($sformatf("c%0d out_w", n_cyc), 32'(out_w), 32'((1 << e.pos_w) - 1));
        chk($sformatf("c%0d carries_w", n_cyc), 32'({ci_w, cd_w}), 32'({e.ci_w, e.cd_w}));
        chk($sformatf("c%0d lock_w", n_cyc), 32'(lock_w), 32'(e.lock));
        chk($sformatf("c%0d pos_s", n_cyc), 32'(pos_s), 32'(e.pos_s));
        chk($sformatf("c%0d out_s", n_cyc), 32'(out_s), 32'((1 << e.pos_s) - 1));
        chk($sformatf("c%0d carries_s", n_cyc), 32'({ci_s, cd_s}), 32'({e.ci_s, e.cd_s}));
        chk($sformatf("c%0d lock_s", n_cyc), 32'(lock_s), 32'(e.lock));
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; fine_en = 1'b0; comp_in = 1'b0; load_pos = '0;

        // Reset state.
        cyc(1, 0, 0, 0, 0);
        chk("reset pos", 32'(pos_w), 32'd5);
        chk("reset out", 32'(out_w), 32'h1f);
        chk("reset carries", 32'({ci_w, cd_w, ci_s, cd_s}), 32'd0);
        chk("reset lock", 32'(lock_w), 32'd0);

        // Four matching down samples take one step on the fourth edge.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        chk("filter pos before 4th", 32'(pos_w), 32'd5);
        cyc(0, 0, 1, 0, 0);
        chk("filter pos", 32'(pos_w), 32'd4);
        chk("filter out", 32'(out_w), 32'h0f);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        chk("broken run pos", 32'(pos_w), 32'd4);

        // Down step at position 0: wrap vs saturate, single-cycle carry.
        cyc(0, 1, 1, 1, 0);
        chk("load 0 pos", 32'(pos_w), 32'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        chk("wrap pos", 32'(pos_w), 32'd5);
        chk("wrap out", 32'(out_w), 32'h1f);
        chk("wrap carry_decr", 32'(cd_w), 32'd1);
        chk("sat pos", 32'(pos_s), 32'd0);
        chk("sat carry_decr", 32'(cd_s), 32'd1);
        cyc(0, 0, 1, 0, 0);
        chk("carry_decr drop", 32'({cd_w, cd_s}), 32'd0);

        // Load clamps and beats fine_en; the filter restarts from zero.
        cyc(0, 1, 1, 1, 7);
        chk("load clamp pos", 32'(pos_w), 32'd5);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0);
        chk("post-load no step", 32'({ci_w, pos_w}), 32'd5);
        cyc(0, 0, 1, 1, 0);
        chk("up wrap pos", 32'(pos_w), 32'd0);
        chk("up wrap carry_incr", 32'(ci_w), 32'd1);
        chk("up sat pos", 32'(pos_s), 32'd5);
        chk("up sat carry_incr", 32'(ci_s), 32'd1);

        // An enable gap discards the partial run.
        cyc(0, 1, 0, 0, 3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        chk("gap pos", 32'(pos_w), 32'd3);
        chk("gap carries", 32'({ci_w, cd_w}), 32'd0);

        // Alternating steps from pos 2 lock on the fifth step.
        cyc(0, 1, 0, 0, 2);
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 4; i++) cyc(0, 0, 1, (b % 2 == 0), 0);
            if (b == 3) chk("lock before 5th step", 32'(lock_w), 32'd0);
        end
        chk("lock at 5th step", 32'(lock_w), 32'd1);
        chk("lock pos", 32'(pos_w), 32'd3);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        chk("lock held after alternating step", 32'(lock_w), 32'd1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        chk("lock drop on repeat step", 32'(lock_w), 32'd0);
        chk("lock drop pos", 32'(pos_w), 32'd1);

        // Relock, then reset beats load and fine_en on the same edge.
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 4; i++) cyc(0, 0, 1, (b % 2 == 0), 0);
        end
        chk("relock", 32'(lock_w), 32'd1);
        cyc(1, 1, 1, 1, 2);
        chk("rst priority pos", 32'(pos_w), 32'd5);
        chk("rst priority lock", 32'(lock_w), 32'd0);

        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
